// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } state_e;

  // Width for a counter whose largest terminal value is max(a..d)-1.
  function automatic int unsigned cnt_bits(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int unsigned retry_bits(input int unsigned max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-stage synchroniser, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pll_ctrl.sv
// PLL reset sequencer and lock supervisor with staggered channel reset release.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS          = 3,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
  parameter int unsigned LOCK_STABLE_CYCLES  = 64,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned RELEASE_STAGGER     = 8,
  parameter int unsigned CNT_W               = 8
) (
  input  logic                                refclk,
  input  logic                                rst,
  input  logic                                pll_locked,
  input  logic                                soft_reset_req,
  input  logic [NUM_CLOCKS-1:0]               chan_en,
  output logic                                pll_rst,
  output logic [NUM_CLOCKS-1:0]               chan_rst_n,
  output logic                                ready,
  output logic                                fault,
  output logic [retry_bits(MAX_RETRIES)-1:0]  retry_cnt,
  output logic [CNT_W-1:0]                    lock_loss_cnt
);

  localparam int unsigned RW     = retry_bits(MAX_RETRIES);
  localparam int unsigned REL_SP = (NUM_CLOCKS - 1) * RELEASE_STAGGER;
  localparam int unsigned CW     = cnt_bits(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                            LOCK_STABLE_CYCLES, REL_SP + 1);

  localparam logic [CW-1:0] C_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_ST_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_REL_LAST = CW'(REL_SP);

  state_e                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [RW-1:0]           r_retry, w_retry_nxt;
  logic [CNT_W-1:0]        r_loss, w_loss_nxt;
  logic [NUM_CLOCKS-1:0]   r_chan, w_chan_nxt;
  logic                    r_pll_rst, r_ready, r_fault;
  logic                    w_pll_rst_nxt, w_ready_nxt, w_fault_nxt;
  logic                    w_locked_s;
  logic                    w_lost;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst),
    .d     (pll_locked),
    .q     (w_locked_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_lost      = 1'b0;
    case (r_state)
      RESET_PLL: if (r_cnt == C_RST_LAST) begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
      WAIT_LOCK: if (w_locked_s) begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end else if (r_cnt == C_TO_LAST) begin
        w_cnt_nxt = '0;
        if (r_retry < RW'(MAX_RETRIES)) begin
          w_retry_nxt = r_retry + RW'(1);
          w_state_nxt = RESET_PLL;
        end else begin
          w_state_nxt = FAULT;
        end
      end
      STABLE: if (!w_locked_s) begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end else if (r_cnt == C_ST_LAST) begin
        w_state_nxt = RELEASE;
        w_cnt_nxt   = '0;
      end
      RELEASE: if (!w_locked_s) begin
        w_lost = 1'b1;
      end else if (r_cnt == C_REL_LAST) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
      RUN: begin
        w_cnt_nxt = '0;
        w_lost    = !w_locked_s;
      end
      FAULT:   w_cnt_nxt = '0;
      default: begin
        w_state_nxt = RESET_PLL;
        w_cnt_nxt   = '0;
      end
    endcase

    // Loss is counted before a concurrent soft reset, both land in RESET_PLL.
    if (w_lost) begin
      w_loss_nxt  = (r_loss == '1) ? r_loss : r_loss + CNT_W'(1);
      w_retry_nxt = '0;
      w_state_nxt = RESET_PLL;
      w_cnt_nxt   = '0;
    end
    if (soft_reset_req) begin
      w_retry_nxt = '0;
      w_state_nxt = RESET_PLL;
      w_cnt_nxt   = '0;
    end

    w_chan_nxt = '0;
    if (w_state_nxt == RUN) begin
      w_chan_nxt = chan_en;
    end else if (w_state_nxt == RELEASE) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        w_chan_nxt[i] = r_chan[i] | (chan_en[i] && (w_cnt_nxt == CW'(i * RELEASE_STAGGER)));
      end
    end

    w_pll_rst_nxt = (w_state_nxt == RESET_PLL) || (w_state_nxt == FAULT);
    w_ready_nxt   = (w_state_nxt == RUN);
    w_fault_nxt   = (w_state_nxt == FAULT);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state   <= RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_chan    <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
      r_chan    <= w_chan_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_ready   <= w_ready_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign chan_rst_n    = r_chan;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

endmodule
